// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter/sequencer for the shared fixed-latency memory port; request-to-ack is LATENCY+1 edges.
// No backpressure beyond hold: requests wait until the sequencer returns to IDLE, and each side stalls until its ack pulse.
module mem_port_arbiter #(
    parameter int LATENCY = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic        bw0,
    input  logic        bw1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        mem_ce_n,
    output logic        mem_oe_n,
    output logic        mem_we_n,
    output logic        mem_bw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wdata_en,
    input  logic [31:0] mem_rdata
);

    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_grant;
    logic          owner;
    logic          wr;

    logic          pick1;
    logic          sel_we;

    // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
    assign pick1  = req1 & (~req0 | ~last_grant);
    assign sel_we = pick1 ? we1 : we0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            wr           <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata        <= '0;
            busy         <= 1'b0;
            mem_ce_n     <= 1'b1;
            mem_oe_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            mem_bw       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wdata_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner        <= pick1;
                        wr           <= sel_we;
                        mem_addr     <= pick1 ? addr1 : addr0;
                        mem_bw       <= pick1 ? bw1 : bw0;
                        mem_wdata    <= pick1 ? wdata1 : wdata0;
                        cnt          <= CNT_LOAD;
                        busy         <= 1'b1;
                        mem_ce_n     <= 1'b0;
                        mem_oe_n     <= sel_we;
                        mem_we_n     <= ~sel_we;
                        mem_wdata_en <= sel_we;
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!wr) begin
                            rdata <= mem_rdata;
                        end
                        mem_ce_n     <= 1'b1;
                        mem_oe_n     <= 1'b1;
                        mem_we_n     <= 1'b1;
                        mem_wdata_en <= 1'b0;
                        ack0         <= ~owner;
                        ack1         <= owner;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    last_grant <= owner;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-level transaction model checked every negedge, plus literal expectations.
module tb_mem_port_arbiter;

    localparam int L = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1, bw0, bw1;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;

    logic        ack0, ack1, busy, mem_ce_n, mem_oe_n, mem_we_n, mem_bw, mem_wdata_en;
    logic [31:0] rdata, mem_addr, mem_wdata;

    logic        d1_ack0, d1_ack1, d1_busy, d1_ce_n, d1_oe_n, d1_we_n, d1_bw, d1_wdata_en;
    logic [31:0] d1_rdata, d1_addr, d1_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(.LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .bw0(bw0), .bw1(bw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
        .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_bw(mem_bw),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_en(mem_wdata_en),
        .mem_rdata(mem_rdata)
    );

    mem_port_arbiter #(.LATENCY(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1), .bw0(bw0), .bw1(bw1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(d1_ack0), .ack1(d1_ack1), .rdata(d1_rdata), .busy(d1_busy),
        .mem_ce_n(d1_ce_n), .mem_oe_n(d1_oe_n), .mem_we_n(d1_we_n), .mem_bw(d1_bw),
        .mem_addr(d1_addr), .mem_wdata(d1_wdata), .mem_wdata_en(d1_wdata_en),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction model: a grant at edge t0 owns the port until edge t0+L+1.
    int          k;
    int          t0;
    bit          m_busy;
    bit          m_port;
    bit          m_we;
    bit          m_lg;
    logic        m_bw;
    logic [31:0] m_addr, m_wdata, m_rdata;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            k = 0; t0 = 0; m_busy = 0; m_port = 0; m_we = 0; m_lg = 1;
            m_bw = 0; m_addr = 0; m_wdata = 0; m_rdata = 0;
        end else begin
            k++;
            if (!m_busy) begin
                if (req0 || req1) begin
                    if (req0 && req1) m_port = (m_lg == 1) ? 1'b0 : 1'b1;
                    else              m_port = req1;
                    m_we    = m_port ? we1 : we0;
                    m_bw    = m_port ? bw1 : bw0;
                    m_addr  = m_port ? addr1 : addr0;
                    m_wdata = m_port ? wdata1 : wdata0;
                    t0      = k;
                    m_busy  = 1;
                end
            end else if (k == t0 + L) begin
                if (!m_we) m_rdata = mem_rdata;
            end else if (k == t0 + L + 1) begin
                m_lg   = m_port;
                m_busy = 0;
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            bit acc, dn;
            acc = m_busy && (k - t0) < L;
            dn  = m_busy && (k - t0) == L;
            check("ce_n",     32'(mem_ce_n),     32'(!acc));
            check("oe_n",     32'(mem_oe_n),     32'(!(acc && !m_we)));
            check("we_n",     32'(mem_we_n),     32'(!(acc && m_we)));
            check("wdata_en", 32'(mem_wdata_en), 32'(acc && m_we));
            check("busy",     32'(busy),         32'(m_busy));
            check("ack0",     32'(ack0),         32'(dn && m_port == 0));
            check("ack1",     32'(ack1),         32'(dn && m_port == 1));
            check("mem_addr", mem_addr,          m_addr);
            check("mem_wdata", mem_wdata,        m_wdata);
            check("mem_bw",   32'(mem_bw),       32'(m_bw));
            check("rdata",    rdata,             m_rdata);
        end
    end

    // Watches the L=4 instance for its first ack; n counts negedges after the request was driven.
    task automatic watch(input int max, input logic [31:0] exp_wd, input bit drop_wd1, input bit drop_req0,
                         output int ack_n, output int ack_port, output int oe_cnt, output int we_cnt,
                         output int wd_bad, output logic [31:0] rd);
        ack_n = -1; ack_port = -1; oe_cnt = 0; we_cnt = 0; wd_bad = 0; rd = '0;
        for (int n = 1; n <= max; n++) begin
            @(negedge clock);
            if (n == 1 && drop_wd1)  wdata1 = 32'h0;
            if (n == 1 && drop_req0) req0 = 1'b0;
            if (!mem_oe_n) oe_cnt++;
            if (!mem_we_n) begin
                we_cnt++;
                if (!mem_wdata_en || mem_wdata !== exp_wd) wd_bad++;
            end
            if (ack0 || ack1) begin
                ack_n = n; ack_port = ack1 ? 1 : 0; rd = rdata;
                break;
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || d1_busy) && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (busy || d1_busy) check("idle_timeout", 32'(n), 32'd0);
        @(negedge clock);
    endtask

    initial begin
        int an, ap, oc, wc, wb;
        logic [31:0] rd;
        int acks_n[3];
        int acks_p[3];
        int na;

        reset_n = 0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; bw0 = 0; bw1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 0;
        repeat (2) @(negedge clock);
        check("rst_ce_n", 32'(mem_ce_n), 32'd1);
        check("rst_oe_n", 32'(mem_oe_n), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset_n = 1;
        @(negedge clock);

        // Single read on port 0
        req0 = 1; we0 = 0; addr0 = 32'h40; bw0 = 1; mem_rdata = 32'hDEADBEEF;
        watch(20, 32'h0, 0, 0, an, ap, oc, wc, wb, rd);
        req0 = 0; bw0 = 0;
        check("rd_ack_cycle", 32'(an), 32'd5);
        check("rd_ack_port", 32'(ap), 32'd0);
        check("rd_oe_cycles", 32'(oc), 32'd4);
        check("rd_data", rd, 32'hDEADBEEF);
        wait_idle();

        // Single write on port 1, wdata changed after the grant
        req1 = 1; we1 = 1; addr1 = 32'h100; wdata1 = 32'h12345678; mem_rdata = 32'h0BAD0BAD;
        watch(20, 32'h12345678, 1, 0, an, ap, oc, wc, wb, rd);
        req1 = 0; we1 = 0;
        check("wr_ack_cycle", 32'(an), 32'd5);
        check("wr_ack_port", 32'(ap), 32'd1);
        check("wr_we_cycles", 32'(wc), 32'd4);
        check("wr_oe_cycles", 32'(oc), 32'd0);
        check("wr_wdata_bad", 32'(wb), 32'd0);
        check("wr_rdata_kept", rd, 32'hDEADBEEF);
        wait_idle();

        // Both requesting from reset: grants 0,1,0 six cycles apart
        reset_n = 0;
        @(negedge clock);
        reset_n = 1;
        @(negedge clock);
        req0 = 1; req1 = 1; addr0 = 32'h10; addr1 = 32'h20; mem_rdata = 32'h5555AAAA;
        na = 0;
        for (int n = 1; n <= 40 && na < 3; n++) begin
            @(negedge clock);
            if (ack0 || ack1) begin
                acks_n[na] = n; acks_p[na] = ack1 ? 1 : 0; na++;
            end
        end
        req0 = 0; req1 = 0;
        check("rr_count", 32'(na), 32'd3);
        if (na == 3) begin
            check("rr_p0", 32'(acks_p[0]), 32'd0);
            check("rr_p1", 32'(acks_p[1]), 32'd1);
            check("rr_p2", 32'(acks_p[2]), 32'd0);
            check("rr_n0", 32'(acks_n[0]), 32'd5);
            check("rr_gap1", 32'(acks_n[1] - acks_n[0]), 32'd6);
            check("rr_gap2", 32'(acks_n[2] - acks_n[1]), 32'd6);
        end
        wait_idle();

        // req0 withdrawn after the grant, then a port 1 read
        req0 = 1; addr0 = 32'h44; mem_rdata = 32'h11112222;
        watch(20, 32'h0, 0, 1, an, ap, oc, wc, wb, rd);
        check("drop_ack_cycle", 32'(an), 32'd5);
        check("drop_ack_port", 32'(ap), 32'd0);
        wait_idle();
        req1 = 1; addr1 = 32'h48; mem_rdata = 32'h33334444;
        watch(20, 32'h0, 0, 0, an, ap, oc, wc, wb, rd);
        req1 = 0;
        check("after_ack_cycle", 32'(an), 32'd5);
        check("after_ack_port", 32'(ap), 32'd1);
        check("after_rdata", rd, 32'h33334444);
        wait_idle();

        // Reset during the second ACCESS cycle
        req0 = 1; addr0 = 32'h80; mem_rdata = 32'h77778888;
        repeat (2) @(negedge clock);
        check("mid_ce_before", 32'(mem_ce_n), 32'd0);
        #2 reset_n = 0;
        #1;
        check("mid_ce_n", 32'(mem_ce_n), 32'd1);
        check("mid_oe_n", 32'(mem_oe_n), 32'd1);
        check("mid_busy", 32'(busy), 32'd0);
        req0 = 0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1;
        wc = 0;
        repeat (8) begin
            @(negedge clock);
            if (ack0 || ack1) wc++;
        end
        check("mid_no_ack", 32'(wc), 32'd0);
        req0 = 1; addr0 = 32'h84; mem_rdata = 32'h9999AAAA;
        watch(20, 32'h0, 0, 0, an, ap, oc, wc, wb, rd);
        req0 = 0;
        check("post_rst_ack_cycle", 32'(an), 32'd5);
        check("post_rst_oe_cycles", 32'(oc), 32'd4);
        wait_idle();

        // LATENCY=1 instance: one ACCESS cycle, ack on the second edge
        req0 = 1; addr0 = 32'h200; mem_rdata = 32'hCAFEF00D;
        an = -1; oc = 0; rd = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clock);
            if (!d1_oe_n) oc++;
            if (d1_ack0) begin
                an = n; rd = d1_rdata; req0 = 0;
                break;
            end
        end
        req0 = 0;
        check("l1_ack_cycle", 32'(an), 32'd2);
        check("l1_oe_cycles", 32'(oc), 32'd1);
        check("l1_rdata", rd, 32'hCAFEF00D);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter and access sequencer for the shared, fixed-latency main-memory port of the multicycle MIPS. Sits between the instruction-fetch side (port 0) and the load/store side (port 1) and the single memory device. Grants one request at a time with round-robin fairness and latches the request's address, byte-width and write data. Holds the memory strobes for `LATENCY` cycles, then returns read data and pulses the winner's `ack`; the core stalls (hold) on each side until it sees that pulse.

## Interface
- `LATENCY`, 16, memory access cycles with strobes held active; legal range ≥ 1
- `clock`  in  1  sole clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req0` / `req1`  in  1  access request, port 0 (fetch) / port 1 (data); level, held until `ack`
- `we0` / `we1`  in  1  1 = write, 0 = read
- `bw0` / `bw1`  in  1  byte-width select, passed to memory unchanged
- `addr0` / `addr1`  in  32  byte address
- `wdata0` / `wdata1`  in  32  write data
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `rdata`  out  32  read data, shared by both ports; valid while `ack0` or `ack1` is high
- `busy`  out  1  high in ACCESS and DONE
- `mem_ce_n`, `mem_oe_n`, `mem_we_n`  out  1  memory strobes, active-low
- `mem_bw`  out  1  latched byte-width
- `mem_addr`  out  32  latched address
- `mem_wdata`  out  32  latched write data
- `mem_wdata_en`  out  1  drive enable for the external tristate buffer
- `mem_rdata`  in  32  data returned by memory

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE.
- IDLE, any request: pick the winner, latch its address, bw, wdata and we; load the counter with `LATENCY-1`; go to ACCESS.
- ACCESS, counter > 0: decrement.
- ACCESS, counter == 0: capture `mem_rdata` into `rdata` (reads only); go to DONE.
- DONE: assert the winner's `ack` for one cycle; update `last_grant` to the winner; go to IDLE.
- Arbitration:
  - only one request high: that port wins;
  - both high: the port ≠ `last_grant` wins;
  - `last_grant` resets to 1, so port 0 wins the first tie.
- Strobes in ACCESS only:
  - `mem_ce_n` = 0;
  - read: `mem_oe_n` = 0, `mem_we_n` = 1, `mem_wdata_en` = 0;
  - write: `mem_we_n` = 0, `mem_oe_n` = 1, `mem_wdata_en` = 1.
  - IDLE and DONE: all strobes 1, `mem_wdata_en` = 0.
- Latched address, bw, wdata and we stay stable for the whole ACCESS; input changes after the grant are ignored.
- Counter width is `$clog2(LATENCY)` with a minimum of 1 bit.
- `rdata` holds its last captured value until the next read completes; writes leave it unchanged.
- Requester drops `req` mid-access: the access still completes and `ack` still pulses. No abort.
- Request arriving during ACCESS or DONE waits and is arbitrated in the next IDLE cycle.
- Reset asserted at any time: FSM → IDLE immediately (async), strobes deassert at once, and an in-flight access is discarded with no `ack`.
- Reset values: `ack0` = `ack1` = 0, `busy` = 0, `mem_ce_n` = `mem_oe_n` = `mem_we_n` = 1, `mem_wdata_en` = 0, `mem_addr` = `mem_wdata` = `rdata` = 0, `mem_bw` = 0, counter = 0, `last_grant` = 1.

## Timing
- Request first sampled high at edge E0 (FSM in IDLE):
  - ACCESS for cycles E0 … E0+`LATENCY`-1;
  - `mem_rdata` sampled at edge E0+`LATENCY`;
  - `ack` and `rdata` valid during the cycle after edge E0+`LATENCY`.
- Request-to-ack latency: `LATENCY`+1 edges.
- Minimum spacing between grant edges: `LATENCY`+2 cycles (IDLE → ACCESS ×`LATENCY` → DONE → IDLE).
- `LATENCY` = 1: exactly one ACCESS cycle.
- Both ports requesting continuously: grants alternate 0, 1, 0, 1 …; neither port waits more than one full access.
- Outputs are registered or decoded from registered state only; no combinational path from `req*` to memory strobes.

## Test plan
- Single read, `LATENCY`=4, `req0` at E0, `addr0`=0x40, memory returns 0xDEADBEEF → `mem_ce_n`/`mem_oe_n` low for exactly 4 cycles; `ack0` high one cycle after E4 with `rdata`=0xDEADBEEF; `ack1` stays 0.
- Single write, `req1`, `we1`=1, `addr1`=0x100, `wdata1`=0x12345678, `wdata1` changed to 0 one cycle after the grant → `mem_we_n` low and `mem_wdata_en` high for 4 cycles; `mem_wdata` stays 0x12345678 throughout; `ack1` pulses once.
- Both requesting from reset, held high → grant order port 0, port 1, port 0; `ack` pulses 6 cycles apart (`LATENCY`=4).
- `req0` dropped after the grant → access runs to completion and `ack0` still pulses; a later `req1` is then served normally.
- `reset_n` pulsed low during the 2nd ACCESS cycle → strobes return to 1 without waiting for a clock edge; no `ack`; after release, a new `req0` is served with full latency.
- `LATENCY`=1 read → one ACCESS cycle, `ack` on the 2nd edge after the request.
